// File: rtl/npcnn_relu_pool.sv
// ReLU followed by non-overlapping PS x PS max pooling over a raster-ordered conv frame.
// A single row of partial window maxima replaces full-frame storage.
module npcnn_relu_pool #(
  parameter int OS = 4,
  parameter int PS = 2,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_done,
  output logic          busy
);

  localparam int NP   = OS / PS;
  localparam int SPAN = PS * NP;
  localparam int CW   = (OS > 1) ? $clog2(OS) : 1;
  localparam int KW   = (NP > 1) ? $clog2(NP) : 1;

  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic [DW-1:0] lb_q [NP];
  logic [DW-1:0] lb_d [NP];
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic          accept, in_range, win_first, win_last, last_col, last_row;
  logic [DW-1:0] relu_v, lb_k, max_v;
  logic [KW-1:0] k;

  assign in_ready  = !rst && !clr && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign relu_v    = in_data[DW-1] ? '0 : in_data;
  assign k         = KW'(32'(c_q) / PS);
  assign in_range  = (32'(r_q) < SPAN) && (32'(c_q) < SPAN);
  assign win_first = (32'(r_q) % PS == 0) && (32'(c_q) % PS == 0);
  assign win_last  = (32'(r_q) % PS == PS - 1) && (32'(c_q) % PS == PS - 1);
  assign last_col  = (c_q == CW'(OS - 1));
  assign last_row  = (r_q == CW'(OS - 1));
  assign lb_k      = lb_q[k];
  // Both operands are post-ReLU, so an unsigned compare is exact.
  assign max_v     = (relu_v > lb_k) ? relu_v : lb_k;

  always_comb begin
    r_d          = r_q;
    c_d          = c_q;
    lb_d         = lb_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    if (accept) begin
      busy_d = 1'b1;
      if (last_col) begin
        c_d = '0;
        if (last_row) begin
          r_d          = '0;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
      if (in_range) begin
        // The closing element of a window goes straight to the output register.
        if (win_last) begin
          out_data_d  = max_v;
          out_valid_d = 1'b1;
        end else if (win_first) begin
          lb_d[k] = relu_v;
        end else begin
          lb_d[k] = max_v;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q          <= '0;
      c_q          <= '0;
      for (int i = 0; i < NP; i++) lb_q[i] <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      r_q          <= r_d;
      c_q          <= c_d;
      lb_q         <= lb_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
